// File: rtl/abs_diff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : abs_diff_pkg
//  Description : Shared definitions for the absolute-difference error sweep:
//                sweep FSM state encoding, operand/error widths and the exact
//                reference |a - b| function.
//  Revision    : 1.0 - initial release
// ============================================================================
package abs_diff_pkg;

    localparam int OP_W  = 2;   // width of each operand a, b
    localparam int ERR_W = 2;   // width of exact result and per-vector error

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Exact reference: unsigned |x - y|, never wraps because the smaller
    // operand is always subtracted from the larger.
    function automatic logic [OP_W-1:0] abs_diff(input logic [OP_W-1:0] x,
                                                 input logic [OP_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage : abs_diff_pkg
`default_nettype wire

// File: rtl/abs_diff_err_calc.sv
`default_nettype none
// ============================================================================
//  Module      : abs_diff_err_calc
//  Description : Combinational per-vector error: err = |approx - exact| and a
//                violation flag raised when err exceeds the threshold ET.
//  Ports       : exact  [1:0] in  - exact reference result
//                approx [1:0] in  - approximate circuit result
//                err    [1:0] out - absolute error
//                viol         out - err > ET
//  Revision    : 1.0 - initial release
// ============================================================================
module abs_diff_err_calc
    import abs_diff_pkg::*;
#(
    parameter int unsigned ET = 3
) (
    input  logic [ERR_W-1:0] exact,
    input  logic [ERR_W-1:0] approx,
    output logic [ERR_W-1:0] err,
    output logic             viol
);

    // One extra bit so the subtraction can never wrap before the abs.
    logic [ERR_W:0] w_diff;

    always_comb begin
        if (approx >= exact) begin
            w_diff = {1'b0, approx} - {1'b0, exact};
        end else begin
            w_diff = {1'b0, exact} - {1'b0, approx};
        end
        err  = w_diff[ERR_W-1:0];
        viol = (32'(w_diff) > ET);
    end

endmodule : abs_diff_err_calc
`default_nettype wire

// File: rtl/abs_diff_err_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : abs_diff_err_sweep
//  Description : Exhaustively drives all 16 input vectors into an external
//                approximate absolute-difference circuit, compares each
//                response against the exact |a - b| and accumulates the
//                maximum error, the saturating error sum and the count of
//                vectors whose error exceeds ET.
//  Ports       : clk, rst_n (async, active low), start (sweep request)
//                vec_o    [3:0] out - stimulus, a = [1:0], b = [3:2]
//                approx_i [1:0] in  - approximate response to vec_o
//                busy, done       out - sweep in progress / results final
//                max_err, sum_err, viol_cnt out - results of last sweep
//  Revision    : 1.0 - initial release
// ============================================================================
module abs_diff_err_sweep
    import abs_diff_pkg::*;
#(
    parameter int unsigned ET   = 3,
    parameter int unsigned N_IN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_o,
    input  logic [1:0]      approx_i,
    output logic            busy,
    output logic            done,
    output logic [1:0]      max_err,
    output logic [5:0]      sum_err,
    output logic [4:0]      viol_cnt
);

    state_t          state_q,   state_d;
    logic            armed_q,   armed_d;   // entry cycle between start and SWEEP
    logic [N_IN-1:0] index_q,   index_d;
    logic [ERR_W-1:0] pexact_q, pexact_d;
    logic [ERR_W-1:0] papprox_q, papprox_d;
    logic            pvld_q,    pvld_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic [1:0]      max_q,     max_d;
    logic [5:0]      sum_q,     sum_d;
    logic [4:0]      viol_q,    viol_d;

    logic [ERR_W-1:0] w_err;
    logic             w_viol;
    logic [6:0]       w_sum_ext;

    assign vec_o = (state_q == ST_SWEEP) ? index_q : '0;

    // Error is evaluated on the pipeline register, one cycle behind sampling.
    abs_diff_err_calc #(
        .ET (ET)
    ) u_calc (
        .exact  (pexact_q),
        .approx (papprox_q),
        .err    (w_err),
        .viol   (w_viol)
    );

    assign w_sum_ext = {1'b0, sum_q} + {5'b0, w_err};

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        index_d   = index_q;
        pexact_d  = pexact_q;
        papprox_d = papprox_q;
        pvld_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        max_d     = max_q;
        sum_d     = sum_q;
        viol_d    = viol_q;

        // Accumulate whatever the pipeline holds; the final vector lands in DRAIN.
        if (pvld_q && (state_q == ST_SWEEP || state_q == ST_DRAIN)) begin
            if (w_err > max_q) max_d = w_err;
            sum_d = w_sum_ext[6] ? 6'd63 : w_sum_ext[5:0];
            if (w_viol) viol_d = viol_q + 5'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (armed_q) begin
                    // Results are held through the entry cycle, cleared here.
                    state_d = ST_SWEEP;
                    armed_d = 1'b0;
                    index_d = '0;
                    max_d   = '0;
                    sum_d   = '0;
                    viol_d  = '0;
                end else if (start) begin
                    armed_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_SWEEP: begin
                pexact_d  = abs_diff(vec_o[1:0], vec_o[3:2]);
                papprox_d = approx_i;
                pvld_d    = 1'b1;
                index_d   = index_q + 1'b1;
                if (index_q == '1) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            index_q   <= '0;
            pexact_q  <= '0;
            papprox_q <= '0;
            pvld_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            max_q     <= '0;
            sum_q     <= '0;
            viol_q    <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            index_q   <= index_d;
            pexact_q  <= pexact_d;
            papprox_q <= papprox_d;
            pvld_q    <= pvld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            max_q     <= max_d;
            sum_q     <= sum_d;
            viol_q    <= viol_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign max_err  = max_q;
    assign sum_err  = sum_q;
    assign viol_cnt = viol_q;

endmodule : abs_diff_err_sweep
`default_nettype wire
